cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Producer end of the Common Data Bus consumed by the reservation stations and the ROB.
- Collects completed results (ROB tag plus value) from NUM_FU functional units, buffers them per unit, and broadcasts at most one result per cycle on a registered CDB using round-robin arbitration.
- Back-pressures each unit when its buffer is full, and drops all in-flight results on a pipeline flush.

Parameters:
- NUM_FU, 4, number of functional-unit result ports.
- ROB_TAG_LEN, 4, ROB tag width; tag 0 is reserved and means "no dependency".
- XLEN, 32, result value width.
- FIFO_DEPTH, 2, result buffer entries per functional unit (power of two, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all buffered results and the CDB register.
- fu_valid  in  NUM_FU  per-unit result valid.
- fu_tag  in  NUM_FU*ROB_TAG_LEN  packed destination ROB tags; unit i occupies bits [i*ROB_TAG_LEN +: ROB_TAG_LEN].
- fu_value  in  NUM_FU*XLEN  packed result values; unit i occupies bits [i*XLEN +: XLEN].
- fu_ready  out  NUM_FU  per-unit accept; a transfer occurs when fu_valid[i] && fu_ready[i].
- cdb_valid  out  1  broadcast valid.
- cdb_rob_tag  out  ROB_TAG_LEN  broadcast tag.
- cdb_value  out  XLEN  broadcast value.
- cdb_fu_id  out  $clog2(NUM_FU)  source unit of the broadcast (debug).
- err_tag0  out  1  sticky flag: a result with tag 0 was offered.

Behaviour:
- Single clock domain. All state is updated on posedge clk. Reset is synchronous, active-high, and takes priority over everything.
- Reset values:
  - FIFOs empty; round-robin pointer = 0.
  - cdb_valid = 0, cdb_rob_tag = 0, cdb_value = 0, cdb_fu_id = 0, err_tag0 = 0.
  - fu_ready is high for every unit in the cycle after reset deasserts.
- fu_ready[i] is combinational and equals (count[i] < FIFO_DEPTH) && !flush && !reset. It does not depend on fu_valid and gives no credit for a same-cycle pop.
- Push: when fu_valid[i] && fu_ready[i] and the tag is nonzero, write {tag, value} to FIFO i at the edge.
- Tag 0 handling: when fu_valid[i] && fu_ready[i] and the tag == 0, the handshake completes but the result is discarded and err_tag0 is set (sticky until reset). Tag 0 is never broadcast.
- Arbitration (combinational over FIFO heads):
  - Candidates are the FIFOs with count > 0.
  - Search starts at the rr pointer and wraps modulo NUM_FU; the first non-empty FIFO is granted.
  - The granted head is popped at the edge.
  - The rr pointer moves to grant+1 (mod NUM_FU), and only when a grant occurs.
- CDB register:
  - On a grant, cdb_valid <= 1 and cdb_rob_tag, cdb_value, cdb_fu_id are loaded from the granted head.
  - With no grant, cdb_valid <= 0 and the data fields hold their previous values.
  - The CDB pulses for exactly one cycle per result; consumers sample it the same cycle.
- Latency: a result accepted at edge k into an empty FIFO with no contention is granted in the following cycle and appears on the CDB after edge k+1. That is 2 cycles from fu_valid assertion, the minimum; there is no bypass path.
- Simultaneous push and pop on the same FIFO: both happen and count is unchanged. A pop from a full FIFO does not raise fu_ready in that same cycle.
- Wrap-around: FIFO read and write pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- Ordering: results from a single unit are broadcast in acceptance order. Between units there is no ordering guarantee beyond round-robin fairness. Any waiting unit is granted within NUM_FU cycles.
- Flush:
  - At the edge, all FIFOs empty, cdb_valid <= 0, and no push or pop occurs (fu_ready is low during the flush cycle).
  - The rr pointer resets to 0. err_tag0 is retained.
  - A result presented during the flush cycle is not accepted; the unit must hold or drop it.
- Reset asserted mid-operation has the same effect as flush, and additionally clears err_tag0 and the CDB data fields.

Test Plan:
- Single result: after reset, FU1 offers tag 5, value 0xDEADBEEF for one cycle → fu_ready[1]=1. cdb_valid is high exactly 2 cycles later with rob_tag=5, value=0xDEADBEEF, fu_id=1, then low.
- Contention: FU0–FU3 each offer one result (tags 1,2,3,4) in the same cycle with rr=0 → four consecutive CDB cycles carrying tags 1,2,3,4, rr ends at 0, no bubbles.
- Back-pressure: CDB load kept away from FU2 by continuous FU0/FU1 traffic while FU2 pushes 3 results back-to-back → fu_ready[2] drops after 2 accepts. The third is accepted only after a pop. FU2's tags appear on the CDB in push order.
- Fairness: FU0 streams continuously while FU3 offers one result → FU3's tag is broadcast within 4 cycles, and FU0 is never starved for more than NUM_FU-1 cycles.
- Tag 0: FU2 offers tag 0, value 7 → the handshake completes, nothing is broadcast, err_tag0=1 and stays 1 after a flush. It clears only on reset.
- Flush: 3 results are buffered across FUs and flush is pulsed → cdb_valid=0 the next cycle, all fu_ready are low during the flush cycle, and none of the buffered tags ever appear. A new result after the flush appears with 2-cycle latency.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus producer: per-unit result FIFOs feeding a registered,
// round-robin arbitrated broadcast of one {ROB tag, value} per cycle.
module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int ROB_TAG_LEN = 4,
  parameter int XLEN        = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*ROB_TAG_LEN-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]      fu_value,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb_valid,
  output logic [ROB_TAG_LEN-1:0]      cdb_rob_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic [$clog2(NUM_FU)-1:0]   cdb_fu_id,
  output logic                        err_tag0
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ROB_TAG_LEN-1:0] tag_mem [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]        val_mem [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr  [NUM_FU];
  logic [PTR_W-1:0]       rd_ptr  [NUM_FU];
  logic [CNT_W-1:0]       count   [NUM_FU];

  logic [FU_W-1:0]   rr;
  logic [FU_W-1:0]   grant_id;
  logic [FU_W-1:0]   cand;
  logic              grant_valid;
  logic [NUM_FU-1:0] accept;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] tag0_hit;

  // Ready deliberately ignores a same-cycle pop to keep it off the arbiter path.
  always_comb begin
    fu_ready = '0;
    accept   = '0;
    push     = '0;
    tag0_hit = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] < DEPTH_C) && !flush && !reset;
      accept[i]   = fu_valid[i] && fu_ready[i];
      push[i]     = accept[i] && (fu_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN] != '0);
      tag0_hit[i] = accept[i] && (fu_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN] == '0);
    end
  end

  // Scan from the highest offset down so the closest non-empty unit to rr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    pop         = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      cand = FU_W'((int'(rr) + k) % NUM_FU);
      if (count[cand] != '0) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = grant_valid && (grant_id == FU_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]] <= fu_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
        val_mem[i][wr_ptr[i]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr          <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_tag <= '0;
      cdb_value   <= '0;
      cdb_fu_id   <= '0;
      err_tag0    <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr        <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (|tag0_hit) err_tag0 <= 1'b1;
      if (grant_valid) begin
        rr          <= FU_W'((int'(grant_id) + 1) % NUM_FU);
        cdb_valid   <= 1'b1;
        cdb_rob_tag <= tag_mem[grant_id][rd_ptr[grant_id]];
        cdb_value   <= val_mem[grant_id][rd_ptr[grant_id]];
        cdb_fu_id   <= grant_id;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: latency, contention,
// back-pressure, fairness, tag-0 handling, flush and reset.
module tb_cdb_arbiter;
  localparam int NUM_FU = 4;
  localparam int TL     = 4;
  localparam int XLEN   = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [NUM_FU-1:0]      fu_valid;
  logic [NUM_FU*TL-1:0]   fu_tag;
  logic [NUM_FU*XLEN-1:0] fu_value;
  logic [NUM_FU-1:0]      fu_ready;
  logic                   cdb_valid;
  logic [TL-1:0]          cdb_rob_tag;
  logic [XLEN-1:0]        cdb_value;
  logic [1:0]             cdb_fu_id;
  logic                   err_tag0;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NUM_FU(NUM_FU), .ROB_TAG_LEN(TL), .XLEN(XLEN), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_value(cdb_value),
    .cdb_fu_id(cdb_fu_id), .err_tag0(err_tag0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i, input logic v, input logic [TL-1:0] t, input logic [XLEN-1:0] val);
    fu_valid[i] = v;
    fu_tag[i*TL +: TL] = t;
    fu_value[i*XLEN +: XLEN] = val;
  endtask

  task automatic idle();
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    #1;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid: got %0b expected 0", cdb_valid); end
    n_checks++; if (cdb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL reset_cdb_tag: got %0h expected 0", cdb_rob_tag); end
    n_checks++; if (cdb_value !== 32'd0) begin n_fail++; $display("FAIL reset_cdb_value: got %0h expected 0", cdb_value); end
    n_checks++; if (cdb_fu_id !== 2'd0) begin n_fail++; $display("FAIL reset_cdb_fu_id: got %0d expected 0", cdb_fu_id); end
    n_checks++; if (err_tag0 !== 1'b0) begin n_fail++; $display("FAIL reset_err_tag0: got %0b expected 0", err_tag0); end
    n_checks++; if (fu_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready_during: got %0h expected 0", fu_ready); end
    reset = 1'b0;
    #1;
    n_checks++; if (fu_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready_after: got %0h expected f", fu_ready); end
  endtask

  task automatic test_single();
    do_reset();
    offer(1, 1'b1, 4'd5, 32'hDEADBEEF);
    #1;
    n_checks++; if (fu_ready[1] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b expected 1", fu_ready[1]); end
    step();
    idle();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0b expected 0", cdb_valid); end
    step();
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", cdb_valid); end
    n_checks++; if (cdb_rob_tag !== 4'd5) begin n_fail++; $display("FAIL single_tag: got %0d expected 5", cdb_rob_tag); end
    n_checks++; if (cdb_value !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_value: got %0h expected deadbeef", cdb_value); end
    n_checks++; if (cdb_fu_id !== 2'd1) begin n_fail++; $display("FAIL single_fu_id: got %0d expected 1", cdb_fu_id); end
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %0b expected 0", cdb_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < NUM_FU; i++) offer(i, 1'b1, 4'(i + 1), 32'h100 + i);
    step();
    idle();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL cont_first: got %0b expected 0", cdb_valid); end
    for (int k = 0; k < NUM_FU; k++) begin
      step();
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'(k + 1) || cdb_fu_id !== 2'(k) || cdb_value !== 32'h100 + k) begin
        n_fail++;
        $display("FAIL cont_slot%0d: got v=%0b tag=%0d id=%0d val=%0h expected v=1 tag=%0d id=%0d val=%0h",
                 k, cdb_valid, cdb_rob_tag, cdb_fu_id, cdb_value, k + 1, k, 32'h100 + k);
      end
    end
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drained: got %0b expected 0", cdb_valid); end
    // rr is back at 0, so FU0 must beat FU3
    offer(3, 1'b1, 4'd9, 32'h9);
    offer(0, 1'b1, 4'd8, 32'h8);
    step();
    idle();
    step();
    n_checks++; if (cdb_rob_tag !== 4'd8 || cdb_fu_id !== 2'd0) begin n_fail++; $display("FAIL cont_rr_first: got tag=%0d id=%0d expected tag=8 id=0", cdb_rob_tag, cdb_fu_id); end
    step();
    n_checks++; if (cdb_rob_tag !== 4'd9 || cdb_fu_id !== 2'd3) begin n_fail++; $display("FAIL cont_rr_second: got tag=%0d id=%0d expected tag=9 id=3", cdb_rob_tag, cdb_fu_id); end
  endtask

  task automatic test_back_pressure();
    int idx = 0;
    logic acc;
    logic exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int q2 [$];
    do_reset();
    for (int cyc = 0; cyc < 17; cyc++) begin
      offer(0, 1'b1, 4'd1, 32'h1);
      offer(1, 1'b1, 4'd2, 32'h2);
      if (idx < 3) offer(2, 1'b1, 4'(10 + idx), 32'h200 + idx);
      else offer(2, 1'b0, 4'd0, 32'h0);
      #1;
      if (cyc < 5) begin
        n_checks++;
        if (fu_ready[2] !== exp_rdy[cyc]) begin n_fail++; $display("FAIL bp_ready_cyc%0d: got %0b expected %0b", cyc, fu_ready[2], exp_rdy[cyc]); end
      end
      acc = fu_valid[2] && fu_ready[2];
      step();
      if (acc) idx++;
      if (cdb_valid && cdb_fu_id == 2'd2) q2.push_back(int'(cdb_rob_tag));
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      if (cdb_valid && cdb_fu_id == 2'd2) q2.push_back(int'(cdb_rob_tag));
    end
    n_checks++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 3", idx); end
    n_checks++; if (q2.size() != 3) begin n_fail++; $display("FAIL bp_broadcasts: got %0d expected 3", q2.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ((k < q2.size() ? q2[k] : -1) != 10 + k) begin
        n_fail++; $display("FAIL bp_order%0d: got %0d expected %0d", k, (k < q2.size() ? q2[k] : -1), 10 + k);
      end
    end
  endtask

  task automatic test_fairness();
    int seen = -1;
    int gap = 0;
    int max_gap = 0;
    int n_fu0 = 0;
    bit started = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      offer(0, 1'b1, 4'd1, 32'h11);
      offer(3, cyc == 0, 4'd7, 32'h77);
      step();
      if (cdb_valid && cdb_fu_id == 2'd3 && cdb_rob_tag == 4'd7 && seen < 0) seen = cyc + 1;
      if (cdb_valid && cdb_fu_id == 2'd0) begin
        started = 1;
        gap = 0;
        n_fu0++;
      end else if (started) begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
    idle();
    step();
    step();
    n_checks++; if (seen != 3) begin n_fail++; $display("FAIL fair_fu3_edges: got %0d expected 3", seen); end
    n_checks++; if (max_gap > NUM_FU - 1) begin n_fail++; $display("FAIL fair_fu0_gap: got %0d expected at most %0d", max_gap, NUM_FU - 1); end
    n_checks++; if (n_fu0 != 18) begin n_fail++; $display("FAIL fair_fu0_count: got %0d expected 18", n_fu0); end
  endtask

  task automatic test_tag0();
    do_reset();
    offer(2, 1'b1, 4'd0, 32'd7);
    #1;
    n_checks++; if (fu_ready[2] !== 1'b1) begin n_fail++; $display("FAIL tag0_ready: got %0b expected 1", fu_ready[2]); end
    step();
    idle();
    n_checks++; if (err_tag0 !== 1'b1) begin n_fail++; $display("FAIL tag0_err_set: got %0b expected 1", err_tag0); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL tag0_broadcast%0d: got %0b expected 0", k, cdb_valid); end
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (err_tag0 !== 1'b1) begin n_fail++; $display("FAIL tag0_after_flush: got %0b expected 1", err_tag0); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (err_tag0 !== 1'b0) begin n_fail++; $display("FAIL tag0_after_reset: got %0b expected 0", err_tag0); end
  endtask

  task automatic test_flush();
    do_reset();
    offer(0, 1'b1, 4'd3, 32'h33);
    offer(1, 1'b1, 4'd4, 32'h44);
    offer(2, 1'b1, 4'd5, 32'h55);
    step();
    idle();
    flush = 1'b1;
    offer(3, 1'b1, 4'd6, 32'h66);
    #1;
    n_checks++; if (fu_ready !== 4'h0) begin n_fail++; $display("FAIL flush_ready: got %0h expected 0", fu_ready); end
    step();
    idle();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cdb: got %0b expected 0", cdb_valid); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak%0d: got v=%0b tag=%0d expected v=0", k, cdb_valid, cdb_rob_tag); end
    end
    offer(1, 1'b1, 4'd9, 32'h99);
    #1;
    n_checks++; if (fu_ready[1] !== 1'b1) begin n_fail++; $display("FAIL flush_new_ready: got %0b expected 1", fu_ready[1]); end
    step();
    idle();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_new_early: got %0b expected 0", cdb_valid); end
    step();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd9 || cdb_fu_id !== 2'd1 || cdb_value !== 32'h99) begin
      n_fail++; $display("FAIL flush_new_result: got v=%0b tag=%0d id=%0d val=%0h expected v=1 tag=9 id=1 val=99", cdb_valid, cdb_rob_tag, cdb_fu_id, cdb_value);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (cdb_rob_tag !== 4'd0 || cdb_value !== 32'd0 || cdb_fu_id !== 2'd0) begin
      n_fail++; $display("FAIL midop_reset_data: got tag=%0d val=%0h id=%0d expected all 0", cdb_rob_tag, cdb_value, cdb_fu_id);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_fairness();
    test_tag0();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
